ccc_reset_sequencer: RTL and testbench
======================================

// Module: ccc_reset_sequencer
// PURPOSE
//  Parametrised successor to the single-output CCC/PLL wrapper: supervises one PLL and sequences
//  NUM_CH fabric reset domains. Controls PLL power-down, filters and times out PLL lock, holds
//  reset, then releases channel resets in staggered order. On lock loss it re-asserts all resets
//  and re-acquires lock. Sits between the PF_CCC instance and the fabric reset tree.
// PARAMETERS
//  NUM_CH        4      number of reset channels, 1..16
//  PD_CYCLES     16     cycles PLL_POWERDOWN_N is held low per power-down/retry
//  LOCK_FILTER   32     consecutive synchronised lock-high cycles required, >=1
//  LOCK_TIMEOUT  65536  max cycles in WAIT_LOCK before retry, > LOCK_FILTER
//  RST_HOLD      64     cycles all resets stay asserted after lock qualifies, >=1
//  STAGGER       8      cycles between successive channel releases, >=1
// PORTS
//  CLK              in   1       sequencer clock, free-running and independent of the PLL output
//  RST              in   1       synchronous reset, active-high
//  ENABLE           in   1       1 = run the sequence; 0 = power down the PLL and hold all resets
//  PLL_LOCK         in   1       raw PLL lock, asynchronous; passes a 2-FF synchroniser (lock_s)
//  CLR_STATUS       in   1       one-cycle pulse; clears LOCK_LOSS_CNT and TIMEOUT_ERR
//  PLL_POWERDOWN_N  out  1       drives the PLL POWERDOWN_N input
//  CH_RST_N         out  NUM_CH  per-channel reset, active-low; bit 0 is released first
//  READY            out  1       1 only in RUN, when all channels are released
//  LOCK_LOSS_CNT    out  8       lock-loss events; saturates at 255
//  TIMEOUT_ERR      out  1       sticky; set by any lock timeout
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Outputs: all registered. Reset values: PLL_POWERDOWN_N=0, CH_RST_N=0, READY=0,
//   LOCK_LOSS_CNT=0, TIMEOUT_ERR=0, state=PD, synchroniser flops=0.
//  FSM states: PD, WAIT_LOCK, HOLD, RELEASE, RUN. Transitions are evaluated each CLK edge.
//  PD: PLL_POWERDOWN_N=0. After PD_CYCLES cycles with ENABLE=1, go to WAIT_LOCK and set
//   PLL_POWERDOWN_N=1. With ENABLE=0 the block stays in PD.
//  WAIT_LOCK:
//   - filt_cnt increments while lock_s=1 and clears on lock_s=0.
//   - When filt_cnt reaches LOCK_FILTER, go to HOLD.
//   - to_cnt counts every cycle spent here. When to_cnt reaches LOCK_TIMEOUT: set TIMEOUT_ERR,
//     go to PD (retry, PLL power-cycled). Retries are unlimited.
//  HOLD: all CH_RST_N=0 for RST_HOLD cycles, then go to RELEASE.
//  RELEASE: CH_RST_N[0]=1 in the first RELEASE cycle; CH_RST_N[k]=1 exactly k*STAGGER cycles later.
//   After CH_RST_N[NUM_CH-1] rises, go to RUN on the next cycle. Released bits stay 1.
//  RUN: READY=1; hold.
//  Lock loss: lock_s=0 while in HOLD, RELEASE or RUN means, on the next edge:
//   - CH_RST_N=0 (all channels) and READY=0;
//   - LOCK_LOSS_CNT increments, saturating;
//   - go to WAIT_LOCK with filt_cnt=to_cnt=0.
//   The PLL is not powered down.
//  ENABLE=0 in any state: next edge goes to PD with all resets asserted, READY=0, PD timer
//   restarted. This has priority over lock loss. A lock-loss count is still recorded if lock
//   also fell in HOLD, RELEASE or RUN.
//  Simultaneous events:
//   - CLR_STATUS with an increment or timeout in the same cycle: the event wins
//     (count=1 / TIMEOUT_ERR=1).
//   - Timeout and filter completion in the same cycle: filter completion wins (go to HOLD).
//  RST mid-operation: everything returns to the reset values within one edge; the PLL is powered down.
//  Counter widths: $clog2(max(param)+1); compares against parameters use the full width, no wrap.
//  Outputs are glitch-free: each is a flop Q, with no combinational output path.
// STRUCTURE
//  Shared package ccc_pkg:
//   - state enum (PD, WAIT_LOCK, HOLD, RELEASE, RUN);
//   - function clog2_min1();
//   - LOSS_CNT_W=8.
//  Sub-module ccc_sync2: 2-FF synchroniser for PLL_LOCK, reset value 0.
//  Everything else (one FSM plus the timer/counter datapath) lives in this module.
// TESTING (params: NUM_CH=3 PD_CYCLES=3 LOCK_FILTER=4 LOCK_TIMEOUT=20 RST_HOLD=6 STAGGER=2)
//  1. Nominal: release RST, ENABLE=1, PLL_LOCK=1 throughout.
//     -> POWERDOWN_N rises 3 cycles after RST falls.
//     -> CH_RST_N[0] rises 6 cycles after the filter completes; [1] 2 cycles later, [2] 4 cycles later.
//     -> READY=1 the next cycle.
//  2. Lock glitch during the filter: PLL_LOCK low for 1 cycle after 3 high lock_s cycles.
//     -> filter restarts; HOLD is entered only after 4 fresh consecutive high cycles.
//     -> LOCK_LOSS_CNT stays 0.
//  3. Timeout: PLL_LOCK held 0.
//     -> after 20 WAIT_LOCK cycles, TIMEOUT_ERR=1 and POWERDOWN_N=0 for 3 cycles, then retry.
//     -> a CLR_STATUS pulse clears TIMEOUT_ERR to 0.
//  4. Lock loss in RUN: drop PLL_LOCK.
//     -> 3 edges later (sync + FSM), CH_RST_N=3'b000, READY=0, LOCK_LOSS_CNT=1.
//     -> relock repeats HOLD/RELEASE without a power-down.
//  5. ENABLE=0 mid-RELEASE, with CH_RST_N=3'b001.
//     -> next cycle CH_RST_N=0 and POWERDOWN_N=0.
//     -> re-enable: the full sequence restarts from PD.
//  6. Saturation: force 260 lock losses -> LOCK_LOSS_CNT holds 255.
//     RST asserted in RUN -> all outputs at reset values after 1 edge.

Source files
------------

// File: rtl/ccc_pkg.sv
// rtl/ccc_pkg.sv - shared types and helpers for the CCC reset sequencer
package ccc_pkg;

  typedef enum logic [2:0] {
    ST_PD,
    ST_WAIT_LOCK,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  localparam int LOSS_CNT_W = 8;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ccc_sync2.sv
// rtl/ccc_sync2.sv - two-flop synchroniser for the asynchronous PLL lock
module ccc_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ccc_reset_sequencer.sv
// rtl/ccc_reset_sequencer.sv - PLL supervision and staggered release of NUM_CH reset domains
module ccc_reset_sequencer
  import ccc_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PD_CYCLES    = 16,
  parameter int LOCK_FILTER  = 32,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 64,
  parameter int STAGGER      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  pll_lock_i,
  input  logic                  clr_status_i,
  output logic                  pll_powerdown_n_o,
  output logic [NUM_CH-1:0]     ch_rst_n_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o,
  output logic                  timeout_err_o
);

  localparam int PD_W   = clog2_min1(PD_CYCLES + 1);
  localparam int FILT_W = clog2_min1(LOCK_FILTER + 1);
  localparam int TO_W   = clog2_min1(LOCK_TIMEOUT + 1);
  localparam int HOLD_W = clog2_min1(RST_HOLD + 1);
  localparam int ST_W   = clog2_min1(STAGGER + 1);
  localparam int IDX_W  = clog2_min1(NUM_CH + 1);

  state_e                state_q;
  logic                  pwdn_n_q;
  logic [NUM_CH-1:0]     ch_rst_n_q;
  logic                  ready_q;
  logic [PD_W-1:0]       pd_cnt_q;
  logic [FILT_W-1:0]     filt_cnt_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [ST_W-1:0]       st_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic lock_s;
  logic lock_lost;
  logic filt_done;
  logic timeout_hit;

  ccc_sync2 u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  assign lock_lost   = !lock_s && (state_q == ST_HOLD || state_q == ST_RELEASE || state_q == ST_RUN);
  assign filt_done   = (state_q == ST_WAIT_LOCK) && lock_s && (filt_cnt_q == FILT_W'(LOCK_FILTER - 1));
  // Filter completion beats a coincident timeout; a disabled block never records a timeout.
  assign timeout_hit = enable_i && (state_q == ST_WAIT_LOCK) && !filt_done &&
                       (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    loss_cnt_d    = loss_cnt_q;
    timeout_err_d = timeout_err_q;
    if (clr_status_i) begin
      loss_cnt_d    = lock_lost ? LOSS_CNT_W'(1) : '0;
      timeout_err_d = timeout_hit;
    end else begin
      if (lock_lost && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
      if (timeout_hit) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_PD;
      pwdn_n_q      <= 1'b0;
      ch_rst_n_q    <= '0;
      ready_q       <= 1'b0;
      pd_cnt_q      <= '0;
      filt_cnt_q    <= '0;
      to_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      st_cnt_q      <= '0;
      idx_q         <= '0;
      loss_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      loss_cnt_q    <= loss_cnt_d;
      timeout_err_q <= timeout_err_d;
      if (!enable_i) begin
        state_q    <= ST_PD;
        pwdn_n_q   <= 1'b0;
        ch_rst_n_q <= '0;
        ready_q    <= 1'b0;
        pd_cnt_q   <= '0;
      end else if (lock_lost) begin
        // Re-acquire lock with the PLL left running.
        state_q    <= ST_WAIT_LOCK;
        ch_rst_n_q <= '0;
        ready_q    <= 1'b0;
        filt_cnt_q <= '0;
        to_cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_PD: begin
            if (pd_cnt_q == PD_W'(PD_CYCLES - 1)) begin
              state_q    <= ST_WAIT_LOCK;
              pwdn_n_q   <= 1'b1;
              filt_cnt_q <= '0;
              to_cnt_q   <= '0;
            end else begin
              pd_cnt_q <= pd_cnt_q + PD_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (filt_done) begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= '0;
            end else if (timeout_hit) begin
              state_q  <= ST_PD;
              pwdn_n_q <= 1'b0;
              pd_cnt_q <= '0;
            end else begin
              filt_cnt_q <= lock_s ? filt_cnt_q + FILT_W'(1) : '0;
              to_cnt_q   <= to_cnt_q + TO_W'(1);
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
              state_q    <= ST_RELEASE;
              ch_rst_n_q <= NUM_CH'(1);
              idx_q      <= IDX_W'(1);
              st_cnt_q   <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_RELEASE: begin
            // idx_q is the next channel to release; reaching NUM_CH means all are out.
            if (idx_q == IDX_W'(NUM_CH)) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else if (st_cnt_q == ST_W'(STAGGER - 1)) begin
              ch_rst_n_q <= ch_rst_n_q | (NUM_CH'(1) << idx_q);
              idx_q      <= idx_q + IDX_W'(1);
              st_cnt_q   <= '0;
            end else begin
              st_cnt_q <= st_cnt_q + ST_W'(1);
            end
          end
          ST_RUN: begin
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= ST_PD;
          end
        endcase
      end
    end
  end

  assign pll_powerdown_n_o = pwdn_n_q;
  assign ch_rst_n_o        = ch_rst_n_q;
  assign ready_o           = ready_q;
  assign lock_loss_cnt_o   = loss_cnt_q;
  assign timeout_err_o     = timeout_err_q;

endmodule

// File: tb/tb_ccc_reset_sequencer.sv
// tb/tb_ccc_reset_sequencer.sv - phase/elapsed-time model plus directed scenarios for the sequencer
module tb_ccc_reset_sequencer;

  localparam int NUM_CH       = 3;
  localparam int PD_CYCLES    = 3;
  localparam int LOCK_FILTER  = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int RST_HOLD     = 6;
  localparam int STAGGER      = 2;

  localparam int PH_PD   = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_REL  = 3;

  logic              clk;
  logic              rst;
  logic              en;
  logic              pll_lock;
  logic              clr;
  logic              pwdn_n;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              ready;
  logic [7:0]        loss_cnt;
  logic              tmo_err;

  int vectors;
  int miscompares;
  bit cmp_en;

  ccc_reset_sequencer #(
    .NUM_CH       (NUM_CH),
    .PD_CYCLES    (PD_CYCLES),
    .LOCK_FILTER  (LOCK_FILTER),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RST_HOLD     (RST_HOLD),
    .STAGGER      (STAGGER)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (en),
    .pll_lock_i        (pll_lock),
    .clr_status_i      (clr),
    .pll_powerdown_n_o (pwdn_n),
    .ch_rst_n_o        (ch_rst_n),
    .ready_o           (ready),
    .lock_loss_cnt_o   (loss_cnt),
    .timeout_err_o     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a phase plus cycles elapsed in it; RELEASE and RUN are one "released" phase.
  int m_ph, m_t, m_run, m_cnt;
  bit m_err, h1, h2, m_s, m_lost, m_tmo;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = PH_PD; m_t = 0; m_run = 0; m_cnt = 0; m_err = 0; h1 = 0; h2 = 0;
    end else begin
      m_s    = h2;
      m_lost = (m_ph >= PH_HOLD) && !m_s;
      m_tmo  = 0;
      if (!en) begin
        m_ph = PH_PD; m_t = 0;
      end else if (m_lost) begin
        m_ph = PH_WAIT; m_t = 0; m_run = 0;
      end else begin
        m_t++;
        if (m_ph == PH_PD && m_t == PD_CYCLES) begin
          m_ph = PH_WAIT; m_t = 0; m_run = 0;
        end else if (m_ph == PH_WAIT) begin
          m_run = m_s ? m_run + 1 : 0;
          if (m_run == LOCK_FILTER) begin
            m_ph = PH_HOLD; m_t = 0;
          end else if (m_t == LOCK_TIMEOUT) begin
            m_ph = PH_PD; m_t = 0; m_tmo = 1;
          end
        end else if (m_ph == PH_HOLD && m_t == RST_HOLD) begin
          m_ph = PH_REL; m_t = 0;
        end
      end
      if (clr) begin
        m_cnt = m_lost ? 1 : 0;
        m_err = m_tmo;
      end else begin
        if (m_lost && m_cnt < 255) m_cnt++;
        if (m_tmo) m_err = 1;
      end
      h2 = h1;
      h1 = pll_lock;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NUM_CH-1:0] e_ch;
      e_ch = '0;
      if (m_ph == PH_REL)
        for (int k = 0; k < NUM_CH; k++) if (m_t >= k * STAGGER) e_ch[k] = 1'b1;
      check("model pwdn_n", {31'd0, pwdn_n}, {31'd0, m_ph != PH_PD});
      check("model ch_rst_n", {29'd0, ch_rst_n}, {29'd0, e_ch});
      check("model ready", {31'd0, ready},
            {31'd0, (m_ph == PH_REL) && (m_t >= (NUM_CH - 1) * STAGGER + 1)});
      check("model loss_cnt", {24'd0, loss_cnt}, m_cnt);
      check("model timeout_err", {31'd0, tmo_err}, {31'd0, m_err});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cmp_en = 0;
    rst = 1'b1; en = 1'b1; pll_lock = 1'b1; clr = 1'b0;
    tick(2);
    cmp_en = 1;
    check("reset pwdn_n", {31'd0, pwdn_n}, 0);
    check("reset ch_rst_n", {29'd0, ch_rst_n}, 0);
    check("reset ready", {31'd0, ready}, 0);
    check("reset loss_cnt", {24'd0, loss_cnt}, 0);
    check("reset timeout_err", {31'd0, tmo_err}, 0);
    rst = 1'b0;

    // Nominal bring-up: HOLD entered at edge 7, releases at 13/15/17, READY at 18.
    tick(2);  check("t1 pwdn low e2", {31'd0, pwdn_n}, 0);
    tick(1);  check("t1 pwdn high e3", {31'd0, pwdn_n}, 1);
    tick(9);  check("t1 ch e12", {29'd0, ch_rst_n}, 3'b000);
    tick(1);  check("t1 ch e13", {29'd0, ch_rst_n}, 3'b001);
    tick(2);  check("t1 ch e15", {29'd0, ch_rst_n}, 3'b011);
    tick(2);  check("t1 ch e17", {29'd0, ch_rst_n}, 3'b111);
              check("t1 ready e17", {31'd0, ready}, 0);
    tick(1);  check("t1 ready e18", {31'd0, ready}, 1);

    // Lock loss in RUN with CLR_STATUS on the same edge: count must read 1.
    pll_lock = 1'b0;
    tick(2);  check("t4 ready before loss", {31'd0, ready}, 1);
    clr = 1'b1;
    tick(1);  clr = 1'b0;
    check("t4 ch after loss", {29'd0, ch_rst_n}, 3'b000);
    check("t4 ready after loss", {31'd0, ready}, 0);
    check("t4 loss_cnt clr+inc", {24'd0, loss_cnt}, 1);
    check("t4 pwdn kept", {31'd0, pwdn_n}, 1);
    pll_lock = 1'b1;
    tick(16); check("t4 ready e37", {31'd0, ready}, 0);
    tick(1);  check("t4 ready e38", {31'd0, ready}, 1);
    check("t4 pwdn relock", {31'd0, pwdn_n}, 1);

    // Single-cycle lock glitch mid-filter delays HOLD to edge 11.
    pll_lock = 1'b1;
    do_reset();
    tick(4);  pll_lock = 1'b0;
    tick(1);  pll_lock = 1'b1;
    tick(11); check("t2 ch e16", {29'd0, ch_rst_n}, 3'b000);
    tick(1);  check("t2 ch e17", {29'd0, ch_rst_n}, 3'b001);
    check("t2 loss_cnt", {24'd0, loss_cnt}, 0);

    // Timeout with no lock, then clear.
    pll_lock = 1'b0;
    do_reset();
    tick(22); check("t3 pwdn e22", {31'd0, pwdn_n}, 1);
              check("t3 err e22", {31'd0, tmo_err}, 0);
    tick(1);  check("t3 pwdn e23", {31'd0, pwdn_n}, 0);
              check("t3 err e23", {31'd0, tmo_err}, 1);
    tick(2);  check("t3 pwdn e25", {31'd0, pwdn_n}, 0);
    tick(1);  check("t3 pwdn e26", {31'd0, pwdn_n}, 1);
    clr = 1'b1;
    tick(1);  clr = 1'b0;
    check("t3 err cleared", {31'd0, tmo_err}, 0);

    // ENABLE drop mid-RELEASE, then full restart from PD.
    pll_lock = 1'b1;
    do_reset();
    tick(13); check("t5 ch e13", {29'd0, ch_rst_n}, 3'b001);
    en = 1'b0;
    tick(1);  check("t5 ch disabled", {29'd0, ch_rst_n}, 3'b000);
              check("t5 pwdn disabled", {31'd0, pwdn_n}, 0);
    en = 1'b1;
    tick(2);  check("t5 pwdn e16", {31'd0, pwdn_n}, 0);
    tick(1);  check("t5 pwdn e17", {31'd0, pwdn_n}, 1);
    tick(9);  check("t5 ch e26", {29'd0, ch_rst_n}, 3'b000);
    tick(1);  check("t5 ch e27", {29'd0, ch_rst_n}, 3'b001);

    // One lock loss per 8-cycle period, well past 255.
    do_reset();
    for (int i = 0; i < 270; i++) begin
      pll_lock = 1'b1; tick(6);
      pll_lock = 1'b0; tick(2);
    end
    check("t6 loss_cnt saturated", {24'd0, loss_cnt}, 255);
    pll_lock = 1'b1;
    tick(30); check("t6 ready in run", {31'd0, ready}, 1);
    rst = 1'b1;
    tick(1);
    check("t6 rst pwdn_n", {31'd0, pwdn_n}, 0);
    check("t6 rst ch_rst_n", {29'd0, ch_rst_n}, 0);
    check("t6 rst ready", {31'd0, ready}, 0);
    check("t6 rst loss_cnt", {24'd0, loss_cnt}, 0);
    check("t6 rst timeout_err", {31'd0, tmo_err}, 0);
    rst = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
